maxpool1d: RTL and testbench
============================

MAXPOOL1D -- requirements
Module: maxpool1d

Interface
REQ-001 The block SHALL take parameter BW, default 8: signed lane width in bits.
REQ-002 The block SHALL take parameter VECTOR_SIZE, default 13: lanes per vector.
REQ-003 The block SHALL take parameter POOL_SIZE, default 2, legal range 2..8: input vectors per pooling window (stride = POOL_SIZE).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_i_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port data_i, input, VECTOR_SIZE*BW bits: packed signed vector; lane k occupies bits [k*BW +: BW].
REQ-007 The block SHALL have port valid_i, input, 1 bit: data_i/last_i are valid.
REQ-008 The block SHALL have port last_i, input, 1 bit: final vector of a frame.
REQ-009 The block SHALL have port ready_o, output, 1 bit: the block accepts a beat this cycle.
REQ-010 The block SHALL have port data_o, output, VECTOR_SIZE*BW bits: pooled signed vector, same packing as data_i.
REQ-011 The block SHALL have port valid_o, output, 1 bit: data_o/last_o are valid.
REQ-012 The block SHALL have port last_o, output, 1 bit: final pooled vector of a frame.
REQ-013 The block SHALL have port ready_i, input, 1 bit: the downstream accepts data_o.

Function
REQ-014 An input beat SHALL transfer only when valid_i && ready_o; an output beat SHALL transfer only when valid_o && ready_i.
REQ-015 ready_o SHALL equal !valid_o || ready_i, combinationally.
REQ-016 Counter cnt (width clog2(POOL_SIZE)) SHALL act as the state: cnt==0 is FIRST, cnt>0 is ACCUM.
REQ-017 On an accepted beat in FIRST with window not closing, the block SHALL set acc<=data_i and cnt<=1.
REQ-018 On an accepted beat in ACCUM with window not closing, the block SHALL set acc<=lane-wise signed max(acc,data_i) and cnt<=cnt+1.
REQ-019 A window SHALL close on an accepted beat where cnt==POOL_SIZE-1 or last_i==1.
REQ-020 On close, the block SHALL load the output register with max(acc,data_i), or data_i alone if cnt==0; SHALL set valid_o<=1, last_o<=last_i and cnt<=0.
REQ-021 Latency SHALL be one cycle from the closing input beat to valid_o.
REQ-022 With last_i, a partial window SHALL be flushed with its partial max; a frame of N vectors SHALL yield ceil(N/POOL_SIZE) outputs, the final one with last_o=1.
REQ-023 Max comparison SHALL be signed two's complement per lane with no widening; for equal values either operand is acceptable (result identical).
REQ-024 While valid_o && !ready_i, data_o, last_o and valid_o SHALL hold stable, and acc/cnt SHALL not change.
REQ-025 On the same cycle an output transfers and a closing input is accepted, the output register SHALL reload with the new result and valid_o SHALL remain 1 (full throughput, no bubble).
REQ-026 When an output transfers and no closing input is accepted, valid_o SHALL clear next cycle.
REQ-027 last_o SHALL be 0 whenever valid_o is 0.

Reset
REQ-028 When rst_i_n==0 at a rising clk_i edge, the block SHALL set valid_o=0, last_o=0, data_o=0, cnt=0, acc=0.
REQ-029 Reset mid-window SHALL discard the partial window with no output; the first beat after reset SHALL start a new window.
REQ-030 During reset, ready_o SHALL read 1, per REQ-015, but no beat SHALL be consumed.

Configuration
REQ-031 With macro MAXPOOL1D_RELU_EN defined, every lane of the value loaded into the output register SHALL be clamped to 0 when negative (fused ReLU); acc itself SHALL stay unclamped.
REQ-032 Without MAXPOOL1D_RELU_EN, data_o SHALL carry the raw signed max.

Verification
REQ-033 POOL_SIZE=2, lane0 inputs 5 then -3, ready_i=1 -> one output, lane0=5, one cycle after 2nd beat.
REQ-034 Frame of 5 vectors, lane0 = 1,7,-2,4,9 with last on 5th -> outputs 7, 4, 9; last_o only on 9.
REQ-035 Lane0 inputs -8 then -3 -> output -3 without MAXPOOL1D_RELU_EN, 0 with it; lane0=127 vs -128 -> 127.
REQ-036 ready_i=0 for 4 cycles while valid_o=1 -> data_o stable, ready_o=0, no input consumed; continuous valid_i with ready_i=1 -> one output per POOL_SIZE cycles, no bubbles.
REQ-037 Assert reset after 1 of 2 beats, then feed 2, 6 -> single output 6, no stale data.

Source files
------------

// File: rtl/maxpool1d.sv
// maxpool1d: streaming 1-D max pooling over POOL_SIZE vectors (stride POOL_SIZE).
// Ports: clk_i, rst_i_n (sync, active-low); in: data_i/valid_i/last_i/ready_o;
//   out: data_o/valid_o/last_o/ready_i. Option: MAXPOOL1D_RELU_EN (fused ReLU).
module maxpool1d #(
  parameter int BW          = 8,
  parameter int VECTOR_SIZE = 13,
  parameter int POOL_SIZE   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i_n,
  input  logic [VECTOR_SIZE*BW-1:0] data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic [VECTOR_SIZE*BW-1:0] data_o,
  output logic                      valid_o,
  output logic                      last_o,
  input  logic                      ready_i
);

  localparam int W  = VECTOR_SIZE * BW;
  localparam int CW = $clog2(POOL_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(POOL_SIZE - 1);

  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  max_v;
  logic [W-1:0]  win_v;
  logic [W-1:0]  out_v;
  logic          accept;
  logic          closing;

  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;
  assign closing = accept && ((cnt == CNT_LAST) || last_i);

  always_comb begin
    max_v = '0;
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      if ($signed(acc[k*BW +: BW]) > $signed(data_i[k*BW +: BW]))
        max_v[k*BW +: BW] = acc[k*BW +: BW];
      else
        max_v[k*BW +: BW] = data_i[k*BW +: BW];
    end
  end

  // cnt==0 means acc holds nothing from this window yet
  assign win_v = (cnt == '0) ? data_i : max_v;

`ifdef MAXPOOL1D_RELU_EN
  always_comb begin
    out_v = '0;
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      if (!win_v[k*BW + BW - 1])
        out_v[k*BW +: BW] = win_v[k*BW +: BW];
    end
  end
`else
  assign out_v = win_v;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i_n) begin
      acc     <= '0;
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      if (closing) begin
        data_o  <= out_v;
        valid_o <= 1'b1;
        last_o  <= last_i;
        cnt     <= '0;
      end else begin
        if (accept) begin
          acc <= win_v;
          cnt <= cnt + CW'(1);
        end
        if (valid_o && ready_i) begin
          valid_o <= 1'b0;
          last_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool1d.sv
// tb_maxpool1d: directed table plus hand sequences for maxpool1d.
// Default parameters (BW=8, VECTOR_SIZE=13, POOL_SIZE=2).
module tb_maxpool1d;

  localparam int BW = 8;
  localparam int VS = 13;
  localparam int PS = 2;

  logic            clk_i = 1'b0;
  logic            rst_i_n;
  logic [VS*BW-1:0] data_i;
  logic            valid_i;
  logic            last_i;
  logic            ready_o;
  logic [VS*BW-1:0] data_o;
  logic            valid_o;
  logic            last_o;
  logic            ready_i;

  int n_chk = 0;
  int n_err = 0;

  maxpool1d #(.BW(BW), .VECTOR_SIZE(VS), .POOL_SIZE(PS)) dut (
    .clk_i   (clk_i),
    .rst_i_n (rst_i_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit v; bit l; int a0; int a1; bit r;
    bit ev; bit el; int e0; int e1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit l, int a0, int a1, bit r,
                              bit ev, bit el, int e0, int e1);
    vec_t t;
    t.v = v; t.l = l; t.a0 = a0; t.a1 = a1; t.r = r;
    t.ev = ev; t.el = el; t.e0 = e0; t.e1 = e1;
    return t;
  endfunction

  function automatic int rl(int x);
`ifdef MAXPOOL1D_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int lane(int k);
    logic signed [BW-1:0] s;
    s = data_o[k*BW +: BW];
    return int'(s);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(bit v, bit l, int a0, int a1, bit r);
    logic [BW-1:0] b0;
    logic [BW-1:0] b1;
    b0 = BW'(a0);
    b1 = BW'(a1);
    for (int k = 0; k < VS; k++) data_i[k*BW +: BW] = b0;
    data_i[BW +: BW] = b1;
    valid_i = v;
    last_i  = l;
    ready_i = r;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(string name, bit ev, bit el, int e0, int e1);
    chk({name, ".valid"}, int'(valid_o), int'(ev));
    chk({name, ".last"}, int'(last_o), int'(el));
    if (ev) begin
      chk({name, ".lane0"}, lane(0), rl(e0));
      chk({name, ".lane1"}, lane(1), rl(e1));
      chk({name, ".laneN"}, lane(VS-1), rl(e0));
    end
  endtask

  initial begin
    // {v,l,a0,a1,r, ev,el,e0,e1}
    tbl.push_back(mk(1,0,   5,  -5,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0,  -3,   3,1, 1,0,  5,   3));
    tbl.push_back(mk(0,0,   0,   0,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0,   1,  -1,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0,   7,  -7,1, 1,0,  7,  -1));
    tbl.push_back(mk(1,0,  -2,   2,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0,   4,  -4,1, 1,0,  4,   2));
    tbl.push_back(mk(1,1,   9,  -9,1, 1,1,  9,  -9));
    tbl.push_back(mk(0,0,   0,   0,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0,  -8, 127,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0,  -3,-128,1, 1,0, -3, 127));
    tbl.push_back(mk(1,0,-128,-128,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0, 127,-128,1, 1,0,127,-128));
    tbl.push_back(mk(1,0,   3,  10,1, 0,0,  0,   0));
    tbl.push_back(mk(0,0,  50,  50,1, 0,0,  0,   0));
    tbl.push_back(mk(1,0,   2,  11,1, 1,0,  3,  11));
    tbl.push_back(mk(1,1,   6,  -6,1, 1,1,  6,  -6));
    tbl.push_back(mk(0,0,   0,   0,1, 0,0,  0,   0));

    // reset with a valid beat offered: nothing may be consumed
    rst_i_n = 1'b0;
    drive(1, 1, 100, 100, 1);
    step();
    step();
    chk("rst.valid", int'(valid_o), 0);
    chk("rst.last", int'(last_o), 0);
    chk("rst.data", (data_o == '0) ? 1 : 0, 1);
    chk("rst.ready", int'(ready_o), 1);
    rst_i_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].a0, tbl[i].a1, tbl[i].r);
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].el,
              tbl[i].e0, tbl[i].e1);
    end

    // backpressure: output held, input not consumed
    drive(1, 0, 10, 10, 1);
    step();
    drive(1, 0, 20, 20, 1);
    step();
    chk_out("bp.out", 1, 0, 20, 20);
    drive(1, 0, 50, 50, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp%0d.ready", c), int'(ready_o), 0);
      step();
      chk_out($sformatf("bp%0d", c), 1, 0, 20, 20);
    end
    drive(1, 0, 50, 50, 1);
    step();
    chk_out("bp.rel", 0, 0, 0, 0);
    drive(1, 0, 40, 40, 1);
    step();
    chk_out("bp.next", 1, 0, 50, 50);

    // continuous stream: one output every PS beats, no bubbles
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, i, -i, 1);
      step();
      if (i % 2 == 0)
        chk_out($sformatf("st%0d", i), 1, 0, i, -i + 1);
      else
        chk_out($sformatf("st%0d", i), 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 1);
    step();
    chk_out("st.idle", 0, 0, 0, 0);

    // reset mid-window discards the partial window
    drive(1, 0, 99, 99, 1);
    step();
    chk_out("mr.first", 0, 0, 0, 0);
    rst_i_n = 1'b0;
    drive(0, 0, 0, 0, 1);
    step();
    chk_out("mr.rst", 0, 0, 0, 0);
    chk("mr.data", (data_o == '0) ? 1 : 0, 1);
    rst_i_n = 1'b1;
    drive(1, 0, 2, 2, 1);
    step();
    chk_out("mr.b2", 0, 0, 0, 0);
    drive(1, 0, 6, 6, 1);
    step();
    chk_out("mr.b6", 1, 0, 6, 6);
    drive(0, 0, 0, 0, 1);
    step();
    chk_out("mr.idle", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
